// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the stereo I2S transmitter.
// Holds the framing modes and the frame/counter sizing helpers.
package i2s_pkg;

   // Framing modes: standard I2S (MSB one BCLK late) or left-justified.
   localparam int I2S_STD = 0;
   localparam int I2S_LJ  = 1;

   // A frame is one left slot followed by one right slot.
   function automatic int frame_len(input int slot_w);
      return 2 * slot_w;
   endfunction

   // Width of a counter that spans positions 0..frame_len-1.
   function automatic int ctr_width(input int slot_w);
      return $clog2(2 * slot_w);
   endfunction

endpackage

// File: rtl/i2s_tx_stereo_frame_ctr.sv
// Frame position counter for the I2S transmitter.
// Counts 0..FRAME-1 on falling BCLK edges and is parked at 0 while disabled.
module i2s_frame_ctr
   import i2s_pkg::*;
#(
   parameter int SLOT_W = 32,
   parameter int CTR_W  = ctr_width(SLOT_W)
) (
   input  logic             bclk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CTR_W-1:0] p,
   output logic             frame_last,
   output logic             slot_sel
);

   localparam logic [CTR_W-1:0] P_LAST = CTR_W'(frame_len(SLOT_W) - 1);
   localparam logic [CTR_W-1:0] P_SLOT = CTR_W'(SLOT_W);

   logic [CTR_W-1:0] p_q;
   logic [CTR_W-1:0] p_d;

   // Next position: hold at 0 when disabled, otherwise wrap after the last slot bit.
   always_comb begin
      p_d = p_q;
      if (!en) begin
         p_d = '0;
      end else if (p_q == P_LAST) begin
         p_d = '0;
      end else begin
         p_d = p_q + CTR_W'(1);
      end
   end

   // Position register, cleared asynchronously.
   always_ff @(negedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p          = p_q;
   assign frame_last = (p_q == P_LAST);
   assign slot_sel   = (p_q >= P_SLOT);

endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified serial transmitter.
// One-pair holding buffer behind a valid/ready input, two MSB-first shifters,
// internally generated LRCLK, and zero or repeat fill on underrun.
//
// Handshake: a pair is taken on a falling BCLK edge where in_valid and
// in_ready are both high; in_ready is high exactly when the buffer is empty
// and does not depend on in_valid.
module i2s_tx_stereo
   import i2s_pkg::*;
#(
   parameter int DATA_W          = 16,
   parameter int SLOT_W          = 32,
   parameter int MODE            = 0,
   parameter int UNDERRUN_REPEAT = 0
) (
   input  logic              bclk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_left,
   input  logic [DATA_W-1:0] in_right,
   output logic              lrclk,
   output logic              dacdat,
   output logic              underrun
);

   localparam int CTR_W = ctr_width(SLOT_W);
   localparam logic [CTR_W-1:0] P_SLOT = CTR_W'(SLOT_W);
   localparam logic [CTR_W-1:0] O_DW   = CTR_W'(DATA_W);
   localparam logic [CTR_W-1:0] O_DW_M = CTR_W'(DATA_W - 1);

   // A slot must hold every data bit plus the I2S delay bit.
   if (SLOT_W < DATA_W + 1) begin : g_bad_slot
      $error("i2s_tx_stereo: SLOT_W must be at least DATA_W+1");
   end
   if (DATA_W < 16 || DATA_W > 32) begin : g_bad_width
      $error("i2s_tx_stereo: DATA_W must be within 16..32");
   end

   logic [CTR_W-1:0] p;
   logic             frame_last;
   logic             slot_sel;

   i2s_frame_ctr #(
      .SLOT_W (SLOT_W),
      .CTR_W  (CTR_W)
   ) u_frame_ctr (
      .bclk       (bclk),
      .rst_n      (rst_n),
      .en         (en),
      .p          (p),
      .frame_last (frame_last),
      .slot_sel   (slot_sel)
   );

   logic              buf_full_q, buf_full_d;
   logic [DATA_W-1:0] buf_l_q, buf_l_d;
   logic [DATA_W-1:0] buf_r_q, buf_r_d;
   logic [DATA_W-1:0] last_l_q, last_l_d;
   logic [DATA_W-1:0] last_r_q, last_r_d;
   logic [DATA_W-1:0] sh_l_q, sh_l_d;
   logic [DATA_W-1:0] sh_r_q, sh_r_d;
   logic              lrclk_q, lrclk_d;
   logic              dacdat_q, dacdat_d;
   logic              underrun_q, underrun_d;

   logic [CTR_W-1:0]  off;
   logic              emit;
   logic              xfer;
   logic              load;

   // Slot offset and whether this position carries a data bit for the mode.
   always_comb begin
      off  = slot_sel ? (p - P_SLOT) : p;
      emit = 1'b0;
      if (MODE == I2S_LJ) begin
         emit = (off <= O_DW_M);
      end else begin
         emit = (off != '0) && (off <= O_DW);
      end
   end

   // Next state for buffer, shifters and the registered serial outputs.
   always_comb begin
      buf_full_d = buf_full_q;
      buf_l_d    = buf_l_q;
      buf_r_d    = buf_r_q;
      last_l_d   = last_l_q;
      last_r_d   = last_r_q;
      sh_l_d     = sh_l_q;
      sh_r_d     = sh_r_q;
      lrclk_d    = 1'b0;
      dacdat_d   = 1'b0;
      underrun_d = 1'b0;

      xfer = in_valid && !buf_full_q;
      load = en && frame_last;

      if (!en) begin
         sh_l_d = '0;
         sh_r_d = '0;
      end else begin
         lrclk_d = slot_sel;
         // Emit from the shifter of the active slot, consuming one bit.
         if (emit) begin
            if (slot_sel) begin
               dacdat_d = sh_r_q[DATA_W-1];
               sh_r_d   = sh_r_q << 1;
            end else begin
               dacdat_d = sh_l_q[DATA_W-1];
               sh_l_d   = sh_l_q << 1;
            end
         end
         // The load at the last position overrides that cycle's shift.
         if (load) begin
            if (buf_full_q) begin
               sh_l_d     = buf_l_q;
               sh_r_d     = buf_r_q;
               last_l_d   = buf_l_q;
               last_r_d   = buf_r_q;
               buf_full_d = 1'b0;
            end else begin
               sh_l_d     = (UNDERRUN_REPEAT != 0) ? last_l_q : '0;
               sh_r_d     = (UNDERRUN_REPEAT != 0) ? last_r_q : '0;
               underrun_d = 1'b1;
            end
         end
      end

      // Accept only into an empty buffer; this also runs while disabled.
      if (xfer) begin
         buf_l_d    = in_left;
         buf_r_d    = in_right;
         buf_full_d = 1'b1;
      end
   end

   // State registers; reset discards any buffered pair.
   always_ff @(negedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         buf_full_q <= 1'b0;
         buf_l_q    <= '0;
         buf_r_q    <= '0;
         last_l_q   <= '0;
         last_r_q   <= '0;
         sh_l_q     <= '0;
         sh_r_q     <= '0;
         lrclk_q    <= 1'b0;
         dacdat_q   <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         buf_full_q <= buf_full_d;
         buf_l_q    <= buf_l_d;
         buf_r_q    <= buf_r_d;
         last_l_q   <= last_l_d;
         last_r_q   <= last_r_d;
         sh_l_q     <= sh_l_d;
         sh_r_q     <= sh_r_d;
         lrclk_q    <= lrclk_d;
         dacdat_q   <= dacdat_d;
         underrun_q <= underrun_d;
      end
   end

   assign in_ready = !buf_full_q;
   assign lrclk    = lrclk_q;
   assign dacdat   = dacdat_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Bench for i2s_tx_stereo: three configurations share one input stream.
//   u0: DATA_W=16 MODE=0 zero-fill, u1: DATA_W=16 MODE=1 repeat-fill,
//   u2: DATA_W=24 MODE=0 zero-fill.
// A frame-level model predicts every output per falling edge; a monitor
// compares on the rising edge.
module tb_i2s_tx_stereo;

   localparam int SLOT  = 32;
   localparam int FRAME = 64;

   logic        bclk = 1'b1;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_l_bus = '0;
   logic [31:0] in_r_bus = '0;
   logic [2:0]  rdy, lr, dd, ur;

   int dw_a[3]   = '{16, 16, 24};
   int mode_a[3] = '{0, 1, 0};
   int rep_a[3]  = '{0, 1, 0};

   // clock / reset block
   always #5 bclk = ~bclk;

   i2s_tx_stereo #(.DATA_W(16), .SLOT_W(32), .MODE(0), .UNDERRUN_REPEAT(0)) u0 (
      .bclk(bclk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_left(in_l_bus[15:0]), .in_right(in_r_bus[15:0]),
      .lrclk(lr[0]), .dacdat(dd[0]), .underrun(ur[0]));
   i2s_tx_stereo #(.DATA_W(16), .SLOT_W(32), .MODE(1), .UNDERRUN_REPEAT(1)) u1 (
      .bclk(bclk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_left(in_l_bus[15:0]), .in_right(in_r_bus[15:0]),
      .lrclk(lr[1]), .dacdat(dd[1]), .underrun(ur[1]));
   i2s_tx_stereo #(.DATA_W(24), .SLOT_W(32), .MODE(0), .UNDERRUN_REPEAT(0)) u2 (
      .bclk(bclk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_left(in_l_bus[23:0]), .in_right(in_r_bus[23:0]),
      .lrclk(lr[2]), .dacdat(dd[2]), .underrun(ur[2]));

   // reference model state
   int          mp = 0;
   bit          m_full = 1'b0;
   logic [31:0] m_buf_l = '0, m_buf_r = '0;
   logic [31:0] cur_l[3], cur_r[3], last_l[3], last_r[3];
   bit          xfer_seen = 1'b0;
   int          n_xfer = 0;

   // scoreboard: {in_ready, {underrun, dacdat, lrclk} x3}
   logic [9:0] exp_q[$];
   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic got, input logic exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0b exp=%0b at %0t", name, got, exp, $time);
   endtask

   // Bit carried at frame position p for a pair, straight from the framing rules.
   function automatic logic ref_bit(input logic [31:0] l, input logic [31:0] r,
                                    input int p, input int mode, input int dw);
      int o;
      logic [31:0] v;
      o = p % SLOT;
      v = (p < SLOT) ? l : r;
      if (mode == 0) begin
         if (o >= 1 && o <= dw) return v[dw - o];
      end else begin
         if (o <= dw - 1) return v[dw - 1 - o];
      end
      return 1'b0;
   endfunction

   // Model: predicts what each DUT holds after every falling edge.
   initial begin
      for (int i = 0; i < 3; i++) begin
         cur_l[i] = '0; cur_r[i] = '0; last_l[i] = '0; last_r[i] = '0;
      end
      forever begin
         logic [9:0] e;
         bit old_full;
         @(negedge bclk);
         e = '0;
         xfer_seen = 1'b0;
         if (!rst_n) begin
            mp = 0;
            m_full = 1'b0;
            for (int i = 0; i < 3; i++) begin
               cur_l[i] = '0; cur_r[i] = '0; last_l[i] = '0; last_r[i] = '0;
            end
            e[9] = 1'b1;
         end else begin
            old_full = m_full;
            if (en) begin
               for (int i = 0; i < 3; i++) begin
                  e[i*3+0] = (mp >= SLOT);
                  e[i*3+1] = ref_bit(cur_l[i], cur_r[i], mp, mode_a[i], dw_a[i]);
               end
               if (mp == FRAME - 1) begin
                  for (int i = 0; i < 3; i++) begin
                     if (old_full) begin
                        cur_l[i] = m_buf_l; cur_r[i] = m_buf_r;
                        last_l[i] = m_buf_l; last_r[i] = m_buf_r;
                     end else begin
                        cur_l[i] = (rep_a[i] != 0) ? last_l[i] : '0;
                        cur_r[i] = (rep_a[i] != 0) ? last_r[i] : '0;
                        e[i*3+2] = 1'b1;
                     end
                  end
                  if (old_full) m_full = 1'b0;
               end
               mp = (mp + 1) % FRAME;
            end else begin
               mp = 0;
               for (int i = 0; i < 3; i++) begin
                  cur_l[i] = '0; cur_r[i] = '0;
               end
            end
            if (in_valid && !old_full) begin
               m_buf_l = in_l_bus;
               m_buf_r = in_r_bus;
               m_full = 1'b1;
               xfer_seen = 1'b1;
               n_xfer++;
            end
            e[9] = !m_full;
         end
         exp_q.push_back(e);
      end
   end

   // Monitor: compares every output once per cycle, away from the active edge.
   initial begin
      forever begin
         logic [9:0] e;
         @(posedge bclk);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL queue_empty got=0 entries exp=1 entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 3; i++) begin
               check($sformatf("lrclk_u%0d", i), lr[i], e[i*3+0]);
               check($sformatf("dacdat_u%0d", i), dd[i], e[i*3+1]);
               check($sformatf("underrun_u%0d", i), ur[i], e[i*3+2]);
               check($sformatf("in_ready_u%0d", i), rdy[i], e[9]);
            end
         end
      end
   end

   // driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge bclk);
      #1;
   endtask

   task automatic push(input logic [31:0] l, input logic [31:0] r);
      int k;
      in_l_bus = l;
      in_r_bus = r;
      in_valid = 1'b1;
      k = 0;
      do begin
         @(negedge bclk);
         #1;
         k++;
      end while (!xfer_seen && k < 300);
      in_valid = 1'b0;
   endtask

   initial begin
      int k;
      logic [31:0] bp_l, bp_r;

      // reset, then enable
      idle(4);
      rst_n = 1'b1;
      en = 1'b1;

      // basic frame for all modes, then underrun (zero vs repeat)
      push(32'h00A5_8001, 32'h00A5_7FFE);
      idle(3 * FRAME);

      // 24-bit pattern for the wide instance
      push(32'hFFA5_A5A5, 32'h005A_5A5A);
      idle(2 * FRAME);

      // back-pressure: valid held high, new incrementing pair after each transfer
      bp_l = $urandom;
      bp_r = $urandom;
      in_l_bus = bp_l;
      in_r_bus = bp_r;
      in_valid = 1'b1;
      for (int c = 0; c < 6 * FRAME; c++) begin
         @(negedge bclk);
         #1;
         if (xfer_seen) begin
            bp_l = bp_l + 1;
            bp_r = bp_r + 1;
            in_l_bus = bp_l;
            in_r_bus = bp_r;
         end
      end
      in_valid = 1'b0;
      idle(2 * FRAME);

      // random pairs with random gaps
      repeat (12) begin
         idle($urandom_range(0, 90));
         push($urandom, $urandom);
      end
      idle(2 * FRAME + 10);

      // enable toggle, with a pair accepted while disabled
      en = 1'b0;
      idle(5);
      push($urandom, $urandom);
      idle(10);
      en = 1'b1;
      idle(3 * FRAME);

      // reset mid-frame with the buffer full
      k = 0;
      while (mp != 2 && k < 200) begin @(negedge bclk); #1; k++; end
      push($urandom, $urandom);
      k = 0;
      while (!(mp == 20 && m_full) && k < 200) begin @(posedge bclk); k++; end
      if (k >= 200) begin
         n_checks++;
         $display("FAIL reset_setup got=timeout exp=p20_full at %0t", $time);
      end
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_lrclk_u%0d", i), lr[i], 1'b0);
         check($sformatf("rst_dacdat_u%0d", i), dd[i], 1'b0);
         check($sformatf("rst_underrun_u%0d", i), ur[i], 1'b0);
         check($sformatf("rst_in_ready_u%0d", i), rdy[i], 1'b1);
      end
      idle(3);
      rst_n = 1'b1;
      idle(FRAME);
      push($urandom, $urandom);
      idle(3 * FRAME);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
